layered_draw_mux: RTL and testbench
===================================

LAYERED_DRAW_MUX -- requirements
Module: layered_draw_mux

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8, the number of drawing layers; index 0 has highest priority.
REQ-002 SHALL have parameter RGB_W, default 8, the pixel colour width.
REQ-003 SHALL have parameter TRANSPARENT, default 8'hFF, the colour key treated as "no draw".
REQ-004 SHALL have parameter BG_COLOR, default 8'h00, the colour output when no layer draws.
REQ-005 SHALL have parameter BLINK_LOG2, default 5, the log2 of the blink period in frames.
REQ-006 SHALL have port clk, input, 1, the single clock for the whole block.
REQ-007 SHALL have port reset, input, 1, the reset: asynchronous and active-high.
REQ-008 SHALL have port drawRequest, input, NUM_LAYERS, the per-layer draw request.
REQ-009 SHALL have port RGB, input, NUM_LAYERS x RGB_W, the per-layer colour.
REQ-010 SHALL have port layerEnable, input, NUM_LAYERS, the per-layer visibility mask.
REQ-011 SHALL have port blinkEnable, input, NUM_LAYERS, the per-layer blink mode.
REQ-012 SHALL have port startOfFrame, input, 1, a one-cycle pulse at frame start.
REQ-013 SHALL have port drawRequestOut, output, 1, high when any qualified layer drew.
REQ-014 SHALL have port RGBOut, output, RGB_W, the selected colour.
REQ-015 SHALL have port layerIdOut, output, $clog2(NUM_LAYERS), the index of the winning layer.
REQ-016 SHALL have port collisionOut, output, NUM_LAYERS, the previous frame's per-layer overlap flags.

Function
REQ-017 A layer SHALL be qualified iff drawRequest[i] & layerEnable[i] & (RGB[i] != TRANSPARENT) & !(blinkEnable[i] & blinkPhase).
REQ-018 Stage 1 SHALL register the qualified vector and the RGB inputs; stage 2 SHALL register the priority-encoded result; fixed latency SHALL be 2 cycles from input to output.
REQ-019 Stage 2 SHALL select the lowest-index qualified layer and drive drawRequestOut=1, RGBOut=RGB of that layer, layerIdOut=its index.
REQ-020 When no layer is qualified, stage 2 SHALL drive drawRequestOut=0, RGBOut=BG_COLOR, layerIdOut=0.
REQ-021 Frame counter width SHALL be BLINK_LOG2 bits, increment on each startOfFrame, and wrap from all-ones to 0.
REQ-022 blinkPhase SHALL equal the frame counter MSB; a blinking layer SHALL be hidden while blinkPhase=1.
REQ-023 The collision accumulator bit i SHALL set sticky when layer i is qualified in stage 1 together with any lower-index qualified layer; bit 0 SHALL never set.
REQ-024 On startOfFrame, collisionOut SHALL load the accumulator value including hits from that same cycle, and the accumulator SHALL clear.
REQ-025 Stage-1 hits in the cycle after startOfFrame SHALL belong to the new frame.
REQ-026 layerEnable and blinkEnable SHALL be sampled every cycle with no shadowing; a change SHALL take effect 2 cycles later at the output.
REQ-027 The pipeline SHALL have no stall and SHALL accept a new pixel every cycle.

Reset
REQ-028 Reset SHALL asynchronously force drawRequestOut=0, RGBOut=BG_COLOR, layerIdOut=0, collisionOut=0, accumulator=0, frame counter=0, and all pipeline registers to "not qualified".
REQ-029 An assertion of reset mid-frame SHALL discard in-flight pixels; the first valid output SHALL appear 2 cycles after reset deasserts.

Structure
REQ-030 Package drawing_pkg SHALL hold the default NUM_LAYERS, RGB_W, TRANSPARENT and BG_COLOR constants and the layer-index typedef.
REQ-031 The priority encoder SHALL be a sub-module layer_priority_enc (combinational: qualified vector -> found, index), instantiated once.

Verification
REQ-032 Layers 2 and 5 request with RGB 8'h1C and 8'hE0 -> 2 cycles later drawRequestOut=1, RGBOut=8'h1C, layerIdOut=2.
REQ-033 Layer 0 requests with RGB=8'hFF and layer 3 with 8'h03 -> RGBOut=8'h03, layerIdOut=3, no collision set on layer 3.
REQ-034 Layers 1 and 4 overlap in one pixel, then startOfFrame -> collisionOut=8'b0001_0000; after a clean frame and the next startOfFrame -> collisionOut=0.
REQ-035 Layer 0 with blinkEnable=1 and BLINK_LOG2=2 -> visible in frames 0-1, hidden in frames 2-3 (RGBOut=BG_COLOR), visible again in frame 4 after wrap.
REQ-036 Reset is asserted with pixels in flight -> outputs go to their reset values immediately with no clock edge; the first post-reset pixel appears at output exactly 2 cycles after reset deasserts.
REQ-037 Collision and startOfFrame occur in the same cycle -> the hit appears in collisionOut and the accumulator reads 0 on the next cycle.

Source files
------------

// File: rtl/drawing_pkg.sv
// Shared constants and types for the layered drawing path.
// Holds the default layer count, colour width, colour key, background colour
// and the layer-index type used by the mux and its priority encoder.
package drawing_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 8;
  localparam int unsigned RGB_W_DEF      = 8;
  localparam int unsigned BLINK_LOG2_DEF = 5;
  localparam int unsigned LAYER_ID_W     = $clog2(NUM_LAYERS_DEF);

  localparam logic [RGB_W_DEF-1:0] TRANSPARENT_DEF = 8'hFF;
  localparam logic [RGB_W_DEF-1:0] BG_COLOR_DEF    = 8'h00;

  typedef logic [LAYER_ID_W-1:0] layer_idx_t;

endpackage

// File: rtl/layer_priority_enc.sv
// Combinational priority encoder: lowest set bit of the qualified vector wins.
// Ports:
//   qualified - per-layer qualified flags (bit 0 = highest priority)
//   found     - at least one layer is qualified
//   index     - index of the winning layer (0 when none)
module layer_priority_enc
  import drawing_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF
) (
  input  logic [NUM_LAYERS-1:0]         qualified,
  output logic                          found,
  output logic [$clog2(NUM_LAYERS)-1:0] index
);

  localparam int unsigned ID_W = $clog2(NUM_LAYERS);

  // Ascending scan; the first hit locks out every higher index.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (qualified[i] && !found) begin
        found = 1'b1;
        index = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/layered_draw_mux.sv
// Two-stage layered pixel mux with colour keying, per-layer enable/blink,
// and per-frame collision reporting.
// Ports:
//   clk, reset     - clock and asynchronous active-high reset
//   drawRequest    - per-layer draw request
//   RGB            - per-layer colour
//   layerEnable    - per-layer visibility mask
//   blinkEnable    - per-layer blink mode
//   startOfFrame   - one-cycle pulse at frame start
//   drawRequestOut - some qualified layer drew (2-cycle latency)
//   RGBOut         - winning colour, or background
//   layerIdOut     - winning layer index, or 0
//   collisionOut   - previous frame's per-layer overlap flags
module layered_draw_mux
  import drawing_pkg::*;
#(
  parameter int unsigned          NUM_LAYERS  = NUM_LAYERS_DEF,
  parameter int unsigned          RGB_W       = RGB_W_DEF,
  parameter logic [RGB_W-1:0]     TRANSPARENT = TRANSPARENT_DEF,
  parameter logic [RGB_W-1:0]     BG_COLOR    = BG_COLOR_DEF,
  parameter int unsigned          BLINK_LOG2  = BLINK_LOG2_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_LAYERS-1:0]               drawRequest,
  input  logic [NUM_LAYERS-1:0][RGB_W-1:0]    RGB,
  input  logic [NUM_LAYERS-1:0]               layerEnable,
  input  logic [NUM_LAYERS-1:0]               blinkEnable,
  input  logic                                startOfFrame,
  output logic                                drawRequestOut,
  output logic [RGB_W-1:0]                    RGBOut,
  output logic [$clog2(NUM_LAYERS)-1:0]       layerIdOut,
  output logic [NUM_LAYERS-1:0]               collisionOut
);

  localparam int unsigned ID_W = $clog2(NUM_LAYERS);

  logic [BLINK_LOG2-1:0]             frame_cnt;
  logic                              blink_phase;
  logic [NUM_LAYERS-1:0]             qual_c;
  logic [NUM_LAYERS-1:0]             qual_q;
  logic [NUM_LAYERS-1:0][RGB_W-1:0]  rgb_q;
  logic [NUM_LAYERS-1:0]             hits_c;
  logic [NUM_LAYERS-1:0]             collision_acc;
  logic                              enc_found;
  logic [ID_W-1:0]                   enc_index;

  assign blink_phase = frame_cnt[BLINK_LOG2-1];

  // Layer qualification on the raw inputs (blink hides during the upper half-period).
  always_comb begin
    qual_c = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      qual_c[i] = drawRequest[i] & layerEnable[i] & (RGB[i] != TRANSPARENT)
                & ~(blinkEnable[i] & blink_phase);
    end
  end

  // A layer collides when any lower-index layer is also qualified in the same pixel.
  always_comb begin
    logic lower;
    lower  = 1'b0;
    hits_c = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      hits_c[i] = qual_q[i] & lower;
      lower     = lower | qual_q[i];
    end
  end

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_enc (
    .qualified (qual_q),
    .found     (enc_found),
    .index     (enc_index)
  );

  // Stage 1: qualified vector and colours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qual_q <= '0;
      rgb_q  <= '0;
    end else begin
      qual_q <= qual_c;
      rgb_q  <= RGB;
    end
  end

  // Stage 2: priority-selected output pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drawRequestOut <= 1'b0;
      RGBOut         <= BG_COLOR;
      layerIdOut     <= '0;
    end else begin
      drawRequestOut <= enc_found;
      RGBOut         <= enc_found ? rgb_q[enc_index] : BG_COLOR;
      layerIdOut     <= enc_found ? enc_index : '0;
    end
  end

  // Frame counter drives the blink phase; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (startOfFrame) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Sticky collision accumulator; frame-start snapshot includes this cycle's hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_acc <= '0;
      collisionOut  <= '0;
    end else if (startOfFrame) begin
      collisionOut  <= collision_acc | hits_c;
      collision_acc <= '0;
    end else begin
      collision_acc <= collision_acc | hits_c;
    end
  end

endmodule

// File: tb/tb_layered_draw_mux.sv
// Directed self-checking bench for layered_draw_mux (BLINK_LOG2 = 2).
module tb_layered_draw_mux;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      draw_req;
  logic [7:0][7:0] rgb;
  logic [7:0]      layer_en;
  logic [7:0]      blink_en;
  logic            sof;
  logic            dro;
  logic [7:0]      rgb_out;
  logic [2:0]      id_out;
  logic [7:0]      coll_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layered_draw_mux #(.BLINK_LOG2(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .drawRequest    (draw_req),
    .RGB            (rgb),
    .layerEnable    (layer_en),
    .blinkEnable    (blink_en),
    .startOfFrame   (sof),
    .drawRequestOut (dro),
    .RGBOut         (rgb_out),
    .layerIdOut     (id_out),
    .collisionOut   (coll_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    draw_req = '0;
    rgb      = '0;
    layer_en = '1;
    blink_en = '0;
    sof      = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (dro !== 1'b0)      begin n_fail++; $display("FAIL reset_dro: got %b expected 0", dro); end
    n_checks++; if (rgb_out !== 8'h00) begin n_fail++; $display("FAIL reset_rgb: got %h expected 00", rgb_out); end
    n_checks++; if (id_out !== 3'd0)   begin n_fail++; $display("FAIL reset_id: got %0d expected 0", id_out); end
    n_checks++; if (coll_out !== 8'h00) begin n_fail++; $display("FAIL reset_coll: got %b expected 0", coll_out); end
  endtask

  task automatic test_priority();
    apply_reset();
    draw_req = 8'b0010_0100;
    rgb[2] = 8'h1C; rgb[5] = 8'hE0;
    tick();
    idle_inputs();
    n_checks++; if (dro !== 1'b0) begin n_fail++; $display("FAIL prio_latency1: got %b expected 0", dro); end
    tick();
    n_checks++; if (dro !== 1'b1)      begin n_fail++; $display("FAIL prio_dro: got %b expected 1", dro); end
    n_checks++; if (rgb_out !== 8'h1C) begin n_fail++; $display("FAIL prio_rgb: got %h expected 1c", rgb_out); end
    n_checks++; if (id_out !== 3'd2)   begin n_fail++; $display("FAIL prio_id: got %0d expected 2", id_out); end
    tick();
    n_checks++; if (dro !== 1'b0)      begin n_fail++; $display("FAIL idle_dro: got %b expected 0", dro); end
    n_checks++; if (rgb_out !== 8'h00) begin n_fail++; $display("FAIL idle_rgb: got %h expected 00", rgb_out); end
    n_checks++; if (id_out !== 3'd0)   begin n_fail++; $display("FAIL idle_id: got %0d expected 0", id_out); end
  endtask

  task automatic test_transparent();
    apply_reset();
    draw_req = 8'b0000_1001;
    rgb[0] = 8'hFF; rgb[3] = 8'h03;
    tick();
    idle_inputs();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n_checks++; if (rgb_out !== 8'h03)  begin n_fail++; $display("FAIL transp_rgb: got %h expected 03", rgb_out); end
    n_checks++; if (id_out !== 3'd3)    begin n_fail++; $display("FAIL transp_id: got %0d expected 3", id_out); end
    n_checks++; if (coll_out !== 8'h00) begin n_fail++; $display("FAIL transp_coll: got %b expected 0", coll_out); end
  endtask

  task automatic test_collision();
    apply_reset();
    draw_req = 8'b0001_0010;
    rgb[1] = 8'h11; rgb[4] = 8'h44;
    tick();
    idle_inputs();
    tick();
    n_checks++; if (id_out !== 3'd1) begin n_fail++; $display("FAIL coll_winner: got %0d expected 1", id_out); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n_checks++; if (coll_out !== 8'b0001_0000) begin n_fail++; $display("FAIL coll_frame1: got %b expected 00010000", coll_out); end
    repeat (3) tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n_checks++; if (coll_out !== 8'h00) begin n_fail++; $display("FAIL coll_clean: got %b expected 0", coll_out); end
  endtask

  task automatic test_sof_same_cycle();
    apply_reset();
    draw_req = 8'b0100_0001;
    rgb[0] = 8'h0A; rgb[6] = 8'h6A;
    tick();
    draw_req = 8'b0000_1100;
    rgb = '0; rgb[2] = 8'h2A; rgb[3] = 8'h3A;
    sof = 1'b1;
    tick();
    idle_inputs();
    n_checks++; if (coll_out !== 8'b0100_0000) begin n_fail++; $display("FAIL sof_same_coll: got %b expected 01000000", coll_out); end
    n_checks++; if (dut.collision_acc !== 8'h00) begin n_fail++; $display("FAIL sof_acc_clear: got %b expected 0", dut.collision_acc); end
    tick();
    n_checks++; if (dut.collision_acc !== 8'b0000_1000) begin n_fail++; $display("FAIL new_frame_acc: got %b expected 00001000", dut.collision_acc); end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n_checks++; if (coll_out !== 8'b0000_1000) begin n_fail++; $display("FAIL new_frame_coll: got %b expected 00001000", coll_out); end
  endtask

  task automatic test_blink();
    logic [4:0] visible;
    visible = 5'b1_0011;
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      draw_req = 8'h01; blink_en = 8'h01; rgb[0] = 8'h55;
      tick();
      idle_inputs();
      tick();
      if (visible[f]) begin
        n_checks++; if (rgb_out !== 8'h55) begin n_fail++; $display("FAIL blink_f%0d_rgb: got %h expected 55", f, rgb_out); end
        n_checks++; if (dro !== 1'b1)      begin n_fail++; $display("FAIL blink_f%0d_dro: got %b expected 1", f, dro); end
      end else begin
        n_checks++; if (rgb_out !== 8'h00) begin n_fail++; $display("FAIL blink_f%0d_rgb: got %h expected 00", f, rgb_out); end
        n_checks++; if (dro !== 1'b0)      begin n_fail++; $display("FAIL blink_f%0d_dro: got %b expected 0", f, dro); end
      end
      sof = 1'b1;
      tick();
      sof = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v_req [4];
    logic [7:0] v_en  [4];
    logic       e_dro [4];
    logic [7:0] e_rgb [4];
    logic [2:0] e_id  [4];
    v_req[0] = 8'b1000_0000; v_en[0] = 8'hFF; e_dro[0] = 1'b1; e_rgb[0] = 8'h77; e_id[0] = 3'd7;
    v_req[1] = 8'b1001_0000; v_en[1] = 8'hFF; e_dro[1] = 1'b1; e_rgb[1] = 8'h44; e_id[1] = 3'd4;
    v_req[2] = 8'b1001_0000; v_en[2] = 8'hEF; e_dro[2] = 1'b1; e_rgb[2] = 8'h77; e_id[2] = 3'd7;
    v_req[3] = 8'b0000_0000; v_en[3] = 8'hFF; e_dro[3] = 1'b0; e_rgb[3] = 8'h00; e_id[3] = 3'd0;
    apply_reset();
    rgb[4] = 8'h44; rgb[7] = 8'h77;
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        draw_req = v_req[c]; layer_en = v_en[c];
      end else begin
        draw_req = '0; layer_en = '1;
      end
      tick();
      if (c >= 1) begin
        n_checks++;
        if (dro !== e_dro[c-1] || rgb_out !== e_rgb[c-1] || id_out !== e_id[c-1]) begin
          n_fail++;
          $display("FAIL b2b_px%0d: got dro=%b rgb=%h id=%0d expected dro=%b rgb=%h id=%0d",
                   c-1, dro, rgb_out, id_out, e_dro[c-1], e_rgb[c-1], e_id[c-1]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    draw_req = 8'b0000_0100; rgb[2] = 8'h1C;
    tick();
    tick();
    n_checks++; if (rgb_out !== 8'h1C) begin n_fail++; $display("FAIL inflight_pre: got %h expected 1c", rgb_out); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (dro !== 1'b0 || rgb_out !== 8'h00 || id_out !== 3'd0)
      begin n_fail++; $display("FAIL async_reset: got dro=%b rgb=%h id=%0d expected 0/00/0", dro, rgb_out, id_out); end
    tick();
    reset = 1'b0;
    draw_req = 8'b0010_0000; rgb = '0; rgb[5] = 8'hE0;
    tick();
    idle_inputs();
    n_checks++; if (dro !== 1'b0) begin n_fail++; $display("FAIL post_reset_c1: got %b expected 0", dro); end
    tick();
    n_checks++; if (dro !== 1'b1 || rgb_out !== 8'hE0 || id_out !== 3'd5)
      begin n_fail++; $display("FAIL post_reset_c2: got dro=%b rgb=%h id=%0d expected 1/e0/5", dro, rgb_out, id_out); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_priority();
    test_transparent();
    test_collision();
    test_sof_same_cycle();
    test_blink();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
